// File: rtl/demux1to8_reg.sv
// demux1to8_reg: registered 1-to-8 word distributor.
// One input word per cycle is steered to a single lane (in_sel) or to all
// lanes (in_bcast). Each lane holds its word until its consumer handshakes.
// A lane being drained in the same cycle counts as free, so a lane can be
// reloaded back-to-back at full rate with no bubble.
module demux1to8_reg #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [2:0]            in_sel,
    input  logic                  in_bcast,
    output logic [7:0]            out_valid,
    input  logic [7:0]            out_ready,
    output logic [8*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]      acc_cnt
);

    logic [7:0]        laneFree;
    logic [7:0]        loadMask;
    logic              xferDone;
    logic [DATA_W-1:0] laneData [8];

    // Free lanes, input readiness and which lanes load this cycle.
    // With in_valid low, xferDone is 0 so a don't-care in_sel/in_bcast
    // cannot reach any state.
    always_comb begin
        laneFree = ~out_valid | out_ready;
        in_ready = in_bcast ? (&laneFree) : laneFree[in_sel];
        xferDone = in_valid && in_ready;
        loadMask = 8'h00;
        if (xferDone) begin
            loadMask = in_bcast ? 8'hFF : (8'h01 << in_sel);
        end
    end

    // Per-lane valid flags: a reload wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (loadMask[i]) begin
                    out_valid[i] <= 1'b1;
                end else if (out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Lane data registers: only a load changes them, so a drained lane keeps its last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                laneData[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (loadMask[i]) begin
                    laneData[i] <= in_data;
                end
            end
        end
    end

    // Accepted-transfer counter; a broadcast is one transfer, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0;
        end else if (xferDone) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
        end
    end

    // Flatten the lane registers onto the output bus.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 8; i++) begin
            out_data[i*DATA_W +: DATA_W] = laneData[i];
        end
    end

endmodule

// File: doc/demux1to8_reg.md
Name: demux1to8_reg

Overview:
- Registered 1-to-8 distributor for 16-bit words, the write-side counterpart of the 8:1 read-select mux in the datapath.
- Accepts one word per cycle on a valid/ready input port.
- Steers each word to one of eight output lanes, or to all lanes at once in broadcast mode.
- Holds each word in a per-lane register until that lane's consumer takes it with its own valid/ready handshake.

Parameters:
- DATA_W, 16, width of each data word and of each output lane.
- CNT_W, 16, width of the accepted-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  DATA_W  word to distribute.
- in_sel  input  3  target lane, 0..7; ignored when in_bcast=1.
- in_bcast  input  1  write the word to all 8 lanes.
- out_valid  output  8  bit i: lane i holds an unconsumed word.
- out_ready  input  8  bit i: lane i consumer takes its word this cycle.
- out_data  output  8*DATA_W  lane i word on bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- acc_cnt  output  CNT_W  count of accepted input transfers.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, every out_data lane=0, acc_cnt=0. in_ready then follows its combinational equation, so with all lanes empty in_ready=1.
- Reset asserted mid-operation discards all held words immediately. No partial state survives.
- Lane i is free when !out_valid[i] || out_ready[i], i.e. it is empty or being drained this cycle.
- in_ready is combinational:
  - in_bcast=0: in_ready = free[in_sel].
  - in_bcast=1: in_ready = AND of free[0..7].
  - in_ready is independent of in_valid.
- A transfer occurs when in_valid && in_ready. On that clock edge:
  - Target lane(s) load in_data and set out_valid, visible the next cycle (latency 1).
  - acc_cnt increments by 1, wrapping from 2^CNT_W-1 to 0. A broadcast counts as 1.
- Lane i not loaded and with out_valid[i] && out_ready[i]: out_valid[i] clears next cycle; out_data lane i keeps its last value.
- Simultaneous drain and reload of the same lane: the new word replaces the old one and out_valid stays 1. This gives one word per cycle sustained throughput per lane with no bubble.
- While out_valid[i]=1 and lane i is not reloaded, out_data lane i is stable.
- out_ready[i] while out_valid[i]=0 has no effect.
- Lanes are independent: draining lane j never affects lane k.
- Blocked input: in_valid=1, in_ready=0 causes no state change. The producer holds in_data, in_sel and in_bcast until it is accepted.
- in_sel and in_bcast are X-tolerant when in_valid=0; no state is updated from them.
- Output lanes are plain registers; there is no combinational path from in_data to out_data.

Test Plan:
- Reset then single write: in_sel=3, in_data=16'hA5A5, in_valid one cycle -> next cycle out_valid=8'h08, lane3=16'hA5A5, acc_cnt=1; out_ready[3]=1 -> out_valid=0 the cycle after.
- Backpressure: lane 5 full, out_ready=0; write to lane 5 with in_data=16'h1234 -> in_ready=0 and lane5 keeps its old word. Raise out_ready[5] -> in_ready=1 the same cycle, lane5=16'h1234 next cycle, out_valid[5] stays 1.
- Broadcast: all lanes empty, in_bcast=1, in_data=16'hBEEF -> next cycle out_valid=8'hFF, all 8 lanes=16'hBEEF, acc_cnt +1. Then lane 2 full with out_ready[2]=0 -> broadcast in_ready=0, while a targeted write to lane 0 with out_ready[0]=1 is accepted.
- Streaming: out_ready[7]=1 held, 10 back-to-back writes of 0..9 to lane 7 -> in_ready=1 every cycle, lane7 shows 0..9 on consecutive cycles, acc_cnt=10.
- Counter wrap: preload by issuing 65535 transfers, then one more -> acc_cnt=0.
- Async reset mid-stream: drop rst_n between clock edges while out_valid=8'h5A -> out_valid=0, all lanes=0, acc_cnt=0 immediately. First write after release behaves as in the single-write case.
